// File: rtl/ttm4_clock_gen.sv
// ttm4_clock_gen: clock and reset conditioner for the TTM4 emulator CPU core.
// Generates the slow emulated CPU clock (stop / slow / fast / manual step),
// the CPU clear, a one-cycle rise marker and an optional rise counter.
// Optional feature macro: TTM4_CLKGEN_CYCLE_COUNTER_EN (enables CYCLES counter).
module ttm4_clock_gen #(
  parameter int unsigned HALF_SLOW = 25000000,
  parameter int unsigned HALF_FAST = 2500000,
  parameter int unsigned STEP_HIGH = 25000,
  parameter int unsigned DEBOUNCE  = 500000
) (
  input  logic        CK,
  input  logic        nCLR,
  input  logic [1:0]  MODE,
  input  logic        nSTEP,
  output logic        CPU_CK,
  output logic        CPU_nCLR,
  output logic        TICK,
  output logic [15:0] CYCLES
);

  localparam int unsigned MAX_AB = (HALF_SLOW > HALF_FAST) ? HALF_SLOW : HALF_FAST;
  localparam int unsigned MAX_CD = (STEP_HIGH > DEBOUNCE) ? STEP_HIGH : DEBOUNCE;
  localparam int unsigned MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW     = $clog2(MAXP);

  localparam logic [CW-1:0] SLOW_END = CW'(HALF_SLOW - 1);
  localparam logic [CW-1:0] FAST_END = CW'(HALF_FAST - 1);
  localparam logic [CW-1:0] STEP_END = CW'(STEP_HIGH - 1);
  localparam logic [CW-1:0] DB_END   = CW'(DEBOUNCE - 1);

  typedef enum logic {LOW, HIGH} state_t;

  logic [1:0]    mode_s1, mode_s2;
  logic          nstep_s1, nstep_s2;
  logic          clr_s1, clr_q;
  logic          stable;
  logic [CW-1:0] db_cnt;
  logic          step_req;
  logic          mode_chg;
  logic [CW-1:0] half_end;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] len, len_n;
  logic          tick_q;

  // Two-flop synchronisers for the switches, the button and the reset release
  always_ff @(posedge CK or negedge nCLR) begin
    if (!nCLR) begin
      mode_s1  <= '0;
      mode_s2  <= '0;
      nstep_s1 <= 1'b1;
      nstep_s2 <= 1'b1;
      clr_s1   <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      mode_s1  <= MODE;
      mode_s2  <= mode_s1;
      nstep_s1 <= nSTEP;
      nstep_s2 <= nstep_s1;
      clr_s1   <= 1'b1;
      clr_q    <= clr_s1;
    end
  end

  // Debounce: accept a new button level after DEBOUNCE cycles of disagreement
  always_ff @(posedge CK or negedge nCLR) begin
    if (!nCLR) begin
      stable <= 1'b1;
      db_cnt <= '0;
    end else if (nstep_s2 == stable) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_END) begin
      stable <= nstep_s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Press event is the accepting cycle itself so the FSM reacts on the same edge
  assign step_req = stable && !nstep_s2 && (db_cnt == DB_END);
  // Synced mode is about to change on this edge
  assign mode_chg = (mode_s1 != mode_s2);
  assign half_end = (mode_s2 == 2'b01) ? SLOW_END : FAST_END;

  // CPU clock phase register
  always_ff @(posedge CK or negedge nCLR) begin
    if (!nCLR) begin
      state  <= LOW;
      cnt    <= '0;
      len    <= '0;
      tick_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      len    <= len_n;
      tick_q <= (state == LOW) && (state_n == HIGH);
    end
  end

  // Next phase: low half counts per mode, high half runs its latched length out
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len;
    unique case (state)
      LOW: begin
        if (!clr_q || mode_chg) begin
          cnt_n = '0;
        end else begin
          unique case (mode_s2)
            2'b01, 2'b10: begin
              if (cnt == half_end) begin
                state_n = HIGH;
                len_n   = half_end;
                cnt_n   = '0;
              end else begin
                cnt_n = cnt + 1'b1;
              end
            end
            2'b11: begin
              cnt_n = '0;
              if (step_req) begin
                state_n = HIGH;
                len_n   = STEP_END;
              end
            end
            default: cnt_n = '0;
          endcase
        end
      end
      HIGH: begin
        if (cnt == len) begin
          state_n = LOW;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = LOW;
        cnt_n   = '0;
      end
    endcase
  end

  assign CPU_CK   = (state == HIGH);
  assign CPU_nCLR = clr_q;
  assign TICK     = tick_q;

`ifdef TTM4_CLKGEN_CYCLE_COUNTER_EN
  logic [15:0] cyc_q;

  // Count CPU clock rises, wrapping at 16 bits
  always_ff @(posedge CK or negedge nCLR) begin
    if (!nCLR) begin
      cyc_q <= '0;
    end else if (tick_q) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end

  assign CYCLES = cyc_q;
`else
  assign CYCLES = '0;
`endif

endmodule
